// File: rtl/sram_fb_pkg.sv
// Shared types and constants for the SRAM framebuffer fill engine.
package sram_fb_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_WRITE,
      S_HOLD,
      S_DONE
   } fb_state_t;

   localparam int RGB_R_W = 5;
   localparam int RGB_G_W = 6;
   localparam int RGB_B_W = 5;
   localparam int RGB_W   = RGB_R_W + RGB_G_W + RGB_B_W;

   // Coordinate width fed to the pattern generator; the grey ramp sum lives here.
   localparam int CRD_W = 11;

   localparam logic [1:0] PAT_SOLID   = 2'd0;
   localparam logic [1:0] PAT_BARS    = 2'd1;
   localparam logic [1:0] PAT_RAMP    = 2'd2;
   localparam logic [1:0] PAT_CHECKER = 2'd3;

   localparam logic [RGB_W-1:0] BAR_WHITE   = 16'hFFFF;
   localparam logic [RGB_W-1:0] BAR_YELLOW  = 16'hFFE0;
   localparam logic [RGB_W-1:0] BAR_CYAN    = 16'h07FF;
   localparam logic [RGB_W-1:0] BAR_GREEN   = 16'h07E0;
   localparam logic [RGB_W-1:0] BAR_MAGENTA = 16'hF81F;
   localparam logic [RGB_W-1:0] BAR_RED     = 16'hF800;
   localparam logic [RGB_W-1:0] BAR_BLUE    = 16'h001F;
   localparam logic [RGB_W-1:0] BAR_BLACK   = 16'h0000;

   function automatic logic [RGB_W-1:0] bar_color(input logic [2:0] idx);
      logic [RGB_W-1:0] c;
      case (idx)
         3'd0:    c = BAR_WHITE;
         3'd1:    c = BAR_YELLOW;
         3'd2:    c = BAR_CYAN;
         3'd3:    c = BAR_GREEN;
         3'd4:    c = BAR_MAGENTA;
         3'd5:    c = BAR_RED;
         3'd6:    c = BAR_BLUE;
         default: c = BAR_BLACK;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/sram_fb_fill_pattern.sv
// Pixel pattern generator: combinational colour select plus one output register,
// loaded with the colour of the pixel about to be written.
module fb_pattern_gen
   import sram_fb_pkg::*;
(
   input  logic             clk50,
   input  logic             rst,
   input  logic             load,
   input  logic [1:0]       mode,
   input  logic [RGB_W-1:0] fill_color,
   input  logic [CRD_W-1:0] x,
   input  logic [CRD_W-1:0] y,
   input  logic [2:0]       bar_idx,
   output logic [RGB_W-1:0] pix_data
);

   logic [CRD_W-1:0] g_sum;
   logic [RGB_W-1:0] pix_next;
   logic             unused_g;

   assign g_sum    = x + y;
   assign unused_g = ^{g_sum[CRD_W-1:8], g_sum[1:0]};

   always_comb begin
      pix_next = fill_color;
      case (mode)
         PAT_SOLID:   pix_next = fill_color;
         PAT_BARS:    pix_next = bar_color(bar_idx);
         // Grey level g = (x+y) mod 256 spread across the three RGB565 fields.
         PAT_RAMP:    pix_next = {g_sum[7 -: RGB_R_W], g_sum[7 -: RGB_G_W], g_sum[7 -: RGB_B_W]};
         PAT_CHECKER: pix_next = (x[3] ^ y[3]) ? ~fill_color : fill_color;
         default:     pix_next = fill_color;
      endcase
   end

   always_ff @(posedge clk50 or posedge rst) begin
      if (rst)       pix_data <= '0;
      else if (load) pix_data <= pix_next;
   end

endmodule

// File: rtl/sram_fb_fill.sv
// Framebuffer fill engine: writes one RGB565 frame into async SRAM after start,
// owning the SRAM bus only while busy.
module sram_fb_fill
   import sram_fb_pkg::*;
#(
   parameter int H_RES     = 640,
   parameter int V_RES     = 480,
   parameter int ADDR_W    = 20,
   parameter int BASE_ADDR = 0,
   parameter int WR_CYCLES = 2
) (
   input  logic              clk50,
   input  logic              rst,
   input  logic              start,
   input  logic [1:0]        mode,
   input  logic [15:0]       fill_color,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] SRAM_ADDR,
   output logic [15:0]       SRAM_DQ,
   output logic              SRAM_CE_N,
   output logic              SRAM_OE_N,
   output logic              SRAM_WE_N,
   output logic              SRAM_UB_N,
   output logic              SRAM_LB_N
);

   // state   | meaning
   // S_IDLE  | bus released, waiting for start
   // S_SETUP | addr/data driven, WE_N high
   // S_WRITE | WE_N low for WR_CYCLES cycles
   // S_HOLD  | WE_N high, addr/data held; next pixel prepared
   // S_DONE  | one-cycle done pulse, busy still high

   localparam int X_W   = $clog2(H_RES);
   localparam int Y_W   = (V_RES > 1) ? $clog2(V_RES) : 1;
   localparam int BAR_W = H_RES / 8;
   localparam int BC_W  = (BAR_W > 1) ? $clog2(BAR_W) : 1;
   localparam int WC_W  = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;

   fb_state_t         state;
   logic              we_n;
   logic [X_W-1:0]    x, x_nxt;
   logic [Y_W-1:0]    y, y_nxt;
   logic [BC_W-1:0]   bar_col, col_nxt;
   logic [2:0]        bar_idx, idx_nxt;
   logic [WC_W-1:0]   wcnt;
   logic [ADDR_W-1:0] addr;
   logic [1:0]        mode_q;
   logic [15:0]       color_q;
   logic              last_x, last_y;

   logic              pg_load;
   logic [1:0]        pg_mode;
   logic [15:0]       pg_color;
   logic [CRD_W-1:0]  pg_x, pg_y;
   logic [2:0]        pg_idx;
   logic [15:0]       pix_data;

   always_comb begin
      last_x = (x == X_W'(H_RES - 1));
      last_y = (y == Y_W'(V_RES - 1));
      x_nxt  = last_x ? '0 : x + X_W'(1);
      y_nxt  = last_x ? y + Y_W'(1) : y;
      col_nxt = bar_col;
      idx_nxt = bar_idx;
      // Bar index advances every BAR_W columns and parks on the last (black) bar.
      if (last_x) begin
         col_nxt = '0;
         idx_nxt = '0;
      end else if (bar_col == BC_W'(BAR_W - 1)) begin
         col_nxt = '0;
         idx_nxt = (bar_idx == 3'd7) ? 3'd7 : bar_idx + 3'd1;
      end else begin
         col_nxt = bar_col + BC_W'(1);
      end
   end

   // In IDLE the generator is primed for pixel (0,0) from the live inputs.
   assign pg_load  = ((state == S_IDLE) && start) || ((state == S_HOLD) && !(last_x && last_y));
   assign pg_mode  = (state == S_IDLE) ? mode : mode_q;
   assign pg_color = (state == S_IDLE) ? fill_color : color_q;
   assign pg_x     = (state == S_IDLE) ? '0 : CRD_W'(x_nxt);
   assign pg_y     = (state == S_IDLE) ? '0 : CRD_W'(y_nxt);
   assign pg_idx   = (state == S_IDLE) ? 3'd0 : idx_nxt;

   fb_pattern_gen u_pattern (
      .clk50      (clk50),
      .rst        (rst),
      .load       (pg_load),
      .mode       (pg_mode),
      .fill_color (pg_color),
      .x          (pg_x),
      .y          (pg_y),
      .bar_idx    (pg_idx),
      .pix_data   (pix_data)
   );

   always_ff @(posedge clk50 or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         we_n    <= 1'b1;
         x       <= '0;
         y       <= '0;
         bar_col <= '0;
         bar_idx <= '0;
         wcnt    <= '0;
         addr    <= ADDR_W'(BASE_ADDR);
         mode_q  <= '0;
         color_q <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  mode_q  <= mode;
                  color_q <= fill_color;
                  x       <= '0;
                  y       <= '0;
                  bar_col <= '0;
                  bar_idx <= '0;
                  addr    <= ADDR_W'(BASE_ADDR);
                  busy    <= 1'b1;
                  state   <= S_SETUP;
               end
            end
            S_SETUP: begin
               we_n  <= 1'b0;
               wcnt  <= WC_W'(WR_CYCLES - 1);
               state <= S_WRITE;
            end
            S_WRITE: begin
               if (wcnt == '0) begin
                  we_n  <= 1'b1;
                  state <= S_HOLD;
               end else begin
                  wcnt <= wcnt - WC_W'(1);
               end
            end
            S_HOLD: begin
               if (last_x && last_y) begin
                  done  <= 1'b1;
                  state <= S_DONE;
               end else begin
                  x       <= x_nxt;
                  y       <= y_nxt;
                  bar_col <= col_nxt;
                  bar_idx <= idx_nxt;
                  addr    <= addr + ADDR_W'(1);
                  state   <= S_SETUP;
               end
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign SRAM_ADDR = busy ? addr     : 'z;
   assign SRAM_DQ   = busy ? pix_data : 'z;
   assign SRAM_CE_N = busy ? 1'b0     : 1'bz;
   assign SRAM_OE_N = busy ? 1'b1     : 1'bz;
   assign SRAM_WE_N = busy ? we_n     : 1'bz;
   assign SRAM_UB_N = busy ? 1'b0     : 1'bz;
   assign SRAM_LB_N = busy ? 1'b0     : 1'bz;

endmodule
